// File: rtl/uart_rx_edge_bit_sampler.sv
// UART RX timing stage: oversampling edge/bit counters and
// mid-bit three-sample majority vote feeding the frame checkers.
module uart_rx_edge_bit_sampler (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       enable,
    input  logic       par_en,
    input  logic [4:0] prescale,
    output logic [4:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       sampled_bit,
    output logic       sample_valid,
    output logic       frame_done
);

    logic [4:0] eff;
    logic [4:0] mid;
    logic [3:0] last;
    logic       wrap;

    logic [4:0] edge_q, edge_d;
    logic [3:0] bit_q, bit_d;
    logic       s0_q, s0_d;
    logic       s1_q, s1_d;
    logic       smp_q, smp_d;
    logic       vld_q, vld_d;
    logic       done_q, done_d;

    // Ratios below 4 cannot fit three samples inside one bit.
    always_comb begin
        eff  = (prescale < 5'd4) ? 5'd4 : prescale;
        mid  = eff >> 1;
        last = par_en ? 4'd10 : 4'd9;
        wrap = (edge_q >= (eff - 5'd1));
    end

    always_comb begin
        edge_d = edge_q;
        bit_d  = bit_q;
        done_d = 1'b0;
        if (!enable) begin
            edge_d = 5'd0;
            bit_d  = 4'd0;
        end else if (wrap) begin
            edge_d = 5'd0;
            if (bit_q >= last) begin
                bit_d  = 4'd0;
                done_d = 1'b1;
            end else begin
                bit_d = bit_q + 4'd1;
            end
        end else begin
            edge_d = edge_q + 5'd1;
        end
    end

    always_comb begin
        s0_d  = s0_q;
        s1_d  = s1_q;
        smp_d = smp_q;
        vld_d = 1'b0;
        if (!enable) begin
            s0_d = 1'b0;
            s1_d = 1'b0;
        end else begin
            if (edge_q == (mid - 5'd1)) s0_d = RX_IN;
            if (edge_q == mid) s1_d = RX_IN;
            if (edge_q == (mid + 5'd1)) begin
                smp_d = (s0_q & s1_q) | (s0_q & RX_IN) | (s1_q & RX_IN);
                vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            edge_q <= 5'd0;
            bit_q  <= 4'd0;
            s0_q   <= 1'b0;
            s1_q   <= 1'b0;
            smp_q  <= 1'b0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            edge_q <= edge_d;
            bit_q  <= bit_d;
            s0_q   <= s0_d;
            s1_q   <= s1_d;
            smp_q  <= smp_d;
            vld_q  <= vld_d;
            done_q <= done_d;
        end
    end

    assign edge_cnt     = edge_q;
    assign bit_cnt      = bit_q;
    assign sampled_bit  = smp_q;
    assign sample_valid = vld_q;
    assign frame_done   = done_q;

endmodule

// File: tb/tb_uart_rx_edge_bit_sampler.sv
// Directed bench for uart_rx_edge_bit_sampler: frames, glitches,
// prescale clamp, enable drop and mid-frame reset.
module tb_uart_rx_edge_bit_sampler;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic       enable;
    logic       par_en;
    logic [4:0] prescale;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sampled_bit;
    logic       sample_valid;
    logic       frame_done;

    int   nvec;
    int   nerr;
    logic exp_s;

    uart_rx_edge_bit_sampler dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .enable       (enable),
        .par_en       (par_en),
        .prescale     (prescale),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid),
        .frame_done   (frame_done)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".edge"}, 32'(edge_cnt), 32'd0);
        chk({tag, ".bit"}, 32'(bit_cnt), 32'd0);
        chk({tag, ".smp"}, 32'(sampled_bit), 32'd0);
        chk({tag, ".vld"}, 32'(sample_valid), 32'd0);
        chk({tag, ".done"}, 32'(frame_done), 32'd0);
    endtask

    // Cycle k of an enabled run sits at edge k%eff of bit k/eff.
    task automatic run_frame(input int psc, input bit par,
                             input logic [10:0] lvl, input logic [10:0] expb,
                             input int ncyc,
                             input int gb1, input int gm1,
                             input int gb2, input int gm2,
                             output int nv, output int nd, output bit coinc);
        int eff, mid, last, e, b, xe, xb;
        bit v, d;
        logic rx;
        eff   = (psc < 4) ? 4 : psc;
        mid   = eff / 2;
        last  = par ? 10 : 9;
        nv    = 0;
        nd    = 0;
        coinc = 0;
        for (int k = 0; k < ncyc; k++) begin
            e  = k % eff;
            b  = k / eff;
            rx = lvl[b];
            if (b == gb1 && ((gm1 >> e) & 1) == 1) rx = ~rx;
            if (b == gb2 && ((gm2 >> e) & 1) == 1) rx = ~rx;
            RX_IN    = rx;
            enable   = 1'b1;
            par_en   = par;
            prescale = 5'(psc);
            tick();
            xe = (e == eff - 1) ? 0 : e + 1;
            xb = (e == eff - 1) ? ((b == last) ? 0 : b + 1) : b;
            v  = (e == mid + 1);
            d  = (e == eff - 1) && (b == last);
            if (v) begin
                exp_s = expb[b];
                nv++;
            end
            if (d) nd++;
            if (v && d) coinc = 1;
            chk("edge_cnt", 32'(edge_cnt), 32'(xe));
            chk("bit_cnt", 32'(bit_cnt), 32'(xb));
            chk("sample_valid", 32'(sample_valid), 32'(v));
            chk("frame_done", 32'(frame_done), 32'(d));
            chk("sampled_bit", 32'(sampled_bit), 32'(exp_s));
        end
    endtask

    initial begin
        int nv, nd;
        bit co;
        nvec     = 0;
        nerr     = 0;
        exp_s    = 1'b0;
        CLK      = 1'b0;
        RST      = 1'b1;
        RX_IN    = 1'b1;
        enable   = 1'b0;
        par_en   = 1'b0;
        prescale = 5'd8;
        tick();
        tick();
        chk_zero("reset");
        RST = 1'b0;

        // start 0, data 0x55 LSB-first, stop 1
        run_frame(8, 0, 11'b01010101010, 11'b01010101010, 80,
                  -1, 0, -1, 0, nv, nd, co);
        chk("clean.nvalid", 32'(nv), 32'd10);
        chk("clean.ndone", 32'(nd), 32'd1);
        chk("clean.bit_end", 32'(bit_cnt), 32'd0);

        // single-edge glitch on bit 1 rejected, two-edge glitch on bit 2 wins
        run_frame(8, 0, 11'b11111111110, 11'b11111111010, 80,
                  1, 16, 2, 24, nv, nd, co);
        chk("glitch.nvalid", 32'(nv), 32'd10);
        chk("glitch.ndone", 32'(nd), 32'd1);

        run_frame(16, 1, 11'b10110011010, 11'b10110011010, 176,
                  -1, 0, -1, 0, nv, nd, co);
        chk("parity.nvalid", 32'(nv), 32'd11);
        chk("parity.ndone", 32'(nd), 32'd1);

        run_frame(2, 0, 11'b01010101010, 11'b01010101010, 40,
                  -1, 0, -1, 0, nv, nd, co);
        chk("clamp.nvalid", 32'(nv), 32'd10);
        chk("clamp.ndone", 32'(nd), 32'd1);
        chk("clamp.coinc", 32'(co), 32'd1);

        // stop at bit 3 edge 4; bit 2 sampled 0, bit 3 would be 1
        run_frame(8, 0, 11'b01010101010, 11'b01010101010, 28,
                  -1, 0, -1, 0, nv, nd, co);
        chk("drop.pre_edge", 32'(edge_cnt), 32'd4);
        chk("drop.pre_bit", 32'(bit_cnt), 32'd3);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drop.edge", 32'(edge_cnt), 32'd0);
            chk("drop.bit", 32'(bit_cnt), 32'd0);
            chk("drop.vld", 32'(sample_valid), 32'd0);
            chk("drop.done", 32'(frame_done), 32'd0);
            chk("drop.smp", 32'(sampled_bit), 32'd0);
        end
        run_frame(8, 0, 11'b01010101010, 11'b01010101010, 80,
                  -1, 0, -1, 0, nv, nd, co);
        chk("reen.nvalid", 32'(nv), 32'd10);
        chk("reen.ndone", 32'(nd), 32'd1);

        run_frame(8, 0, 11'b01010101010, 11'b01010101010, 20,
                  -1, 0, -1, 0, nv, nd, co);
        chk("rst.pre_smp", 32'(sampled_bit), 32'd1);
        RST    = 1'b1;
        enable = 1'b1;
        RX_IN  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_zero("rst_hold");
        end
        exp_s = 1'b0;
        RST   = 1'b0;
        run_frame(8, 0, 11'b01010101010, 11'b01010101010, 80,
                  -1, 0, -1, 0, nv, nd, co);
        chk("post_rst.nvalid", 32'(nv), 32'd10);
        chk("post_rst.ndone", 32'(nd), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
